// File: rtl/daytime_lane_scheduler_if.sv
// Lane-count input bus and lamp-driver output bus of the daytime lane scheduler.
// master = counter/lamp side, slave = scheduler.
interface daytime_lane_scheduler_if;
    logic [63:0] car_counts;
    logic [7:0]  lane_output;

    modport master (
        output car_counts,
        input  lane_output
    );

    modport slave (
        input  car_counts,
        output lane_output
    );
endinterface

// File: rtl/daytime_lane_scheduler.sv
// Four-way, two-lanes-per-approach daytime traffic-light scheduler: greens the
// highest-demand approach with min/max green times and all-red clearance.
module daytime_lane_scheduler #(
    parameter int unsigned MIN_GREEN    = 2,
    parameter int unsigned MAX_GREEN    = 6,
    parameter int unsigned CLEAR_CYCLES = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    daytime_lane_scheduler_if.slave bus
);

    localparam int unsigned GW = (MAX_GREEN    < 1) ? 1 : $clog2(MAX_GREEN + 1);
    localparam int unsigned CW = (CLEAR_CYCLES < 1) ? 1 : $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_CLEAR
    } state_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    state_t         state_q, state_d;
    dir_t           dir_q, dir_d;
    logic [GW-1:0]  green_cnt_q, green_cnt_d;
    logic [CW-1:0]  clear_cnt_q, clear_cnt_d;
    logic [7:0]     lane_output_q, lane_output_d;

    logic [8:0]     demand [4];
    logic [8:0]     best_all_val, best_ex_val, cur_demand;
    dir_t           best_all_dir, best_ex_dir;
    logic           any_demand, other_demand;

    always_comb begin
        for (int unsigned d = 0; d < 4; d++) begin
            demand[d] = {1'b0, bus.car_counts[16*d +: 8]} + {1'b0, bus.car_counts[16*d+8 +: 8]};
        end
    end

    // Strict '>' scanning N..W makes ties fall to the earlier approach.
    // The excluded scan skips the direction that held the last green.
    always_comb begin
        best_all_val = '0;
        best_all_dir = DIR_N;
        best_ex_val  = '0;
        best_ex_dir  = DIR_N;
        other_demand = 1'b0;
        for (int unsigned d = 0; d < 4; d++) begin
            if (demand[d] > best_all_val) begin
                best_all_val = demand[d];
                best_all_dir = dir_t'(2'(d));
            end
            if (2'(d) != dir_q) begin
                if (demand[d] > best_ex_val) begin
                    best_ex_val = demand[d];
                    best_ex_dir = dir_t'(2'(d));
                end
                if (demand[d] != '0) begin
                    other_demand = 1'b1;
                end
            end
        end
    end

    assign any_demand = (best_all_val != '0);
    assign cur_demand = demand[dir_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dir_q         <= DIR_N;
            green_cnt_q   <= '0;
            clear_cnt_q   <= '0;
            lane_output_q <= '0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            green_cnt_q   <= green_cnt_d;
            clear_cnt_q   <= clear_cnt_d;
            lane_output_q <= lane_output_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        green_cnt_d = green_cnt_q;
        clear_cnt_d = clear_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_demand) begin
                    state_d     = ST_GREEN;
                    dir_d       = best_all_dir;
                    green_cnt_d = GW'(1);
                end
            end
            ST_GREEN: begin
                if ((green_cnt_q >= GW'(MIN_GREEN)) && (cur_demand == '0)) begin
                    state_d     = ST_CLEAR;
                    clear_cnt_d = CW'(1);
                end else if ((green_cnt_q >= GW'(MAX_GREEN)) && other_demand) begin
                    state_d     = ST_CLEAR;
                    clear_cnt_d = CW'(1);
                end else if (green_cnt_q < GW'(MAX_GREEN)) begin
                    green_cnt_d = green_cnt_q + GW'(1);
                end
            end
            ST_CLEAR: begin
                if (clear_cnt_q >= CW'(CLEAR_CYCLES)) begin
                    if (best_ex_val != '0) begin
                        state_d     = ST_GREEN;
                        dir_d       = best_ex_dir;
                        green_cnt_d = GW'(1);
                    end else if (cur_demand != '0) begin
                        state_d     = ST_GREEN;
                        green_cnt_d = GW'(1);
                    end else begin
                        state_d     = ST_IDLE;
                        green_cnt_d = '0;
                    end
                end else begin
                    clear_cnt_d = clear_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                green_cnt_d = '0;
            end
        endcase
    end

    // Lamps are derived from the next state so the new pattern appears right after the edge.
    always_comb begin
        lane_output_d = '0;
        if (state_d == ST_GREEN) begin
            case (dir_d)
                DIR_N:   lane_output_d = 8'b1100_0000;
                DIR_E:   lane_output_d = 8'b0011_0000;
                DIR_S:   lane_output_d = 8'b0000_1100;
                DIR_W:   lane_output_d = 8'b0000_0011;
                default: lane_output_d = '0;
            endcase
        end
    end

    assign bus.lane_output = lane_output_q;

endmodule

// File: tb/tb_daytime_lane_scheduler.sv
// Scoreboard bench for daytime_lane_scheduler: directed count vectors with
// hand-computed lamp patterns, checked by an independent monitor process.
module tb_daytime_lane_scheduler;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    logic clk_en;
    int   n_vec;
    int   n_miss;
    sb_entry_t sb_q[$];

    daytime_lane_scheduler_if bus ();

    daytime_lane_scheduler #(
        .MIN_GREEN   (2),
        .MAX_GREEN   (6),
        .CLEAR_CYCLES(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Lane i occupies [8i+7:8i]: N1,N2,E1,E2,S1,S2,W1,W2.
    function automatic logic [63:0] mk(input int n1, n2, e1, e2, s1, s2, w1, w2);
        logic [63:0] v;
        v = {8'(w2), 8'(w1), 8'(s2), 8'(s1), 8'(e2), 8'(e1), 8'(n2), 8'(n1)};
        return v;
    endfunction

    task automatic step(input logic [63:0] counts, input logic [7:0] exp, input string name);
        sb_entry_t e;
        @(negedge clk);
        bus.car_counts = counts;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input logic [7:0] exp, input string name);
        n_vec++;
        if (bus.lane_output !== exp) begin
            n_miss++;
            $display("FAIL %s: lane_output=%b expected=%b", name, bus.lane_output, exp);
        end
    endtask

    always @(posedge clk) begin
        sb_entry_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (bus.lane_output !== e.exp) begin
                n_miss++;
                $display("FAIL %s: lane_output=%b expected=%b at %0t", e.name, bus.lane_output, e.exp, $time);
            end
        end
    end

    initial begin
        logic [63:0] z;
        z      = '0;
        n_vec  = 0;
        n_miss = 0;
        clk    = 1'b0;
        clk_en = 1'b1;
        rst_n  = 1'b0;
        bus.car_counts = z;
        #1;
        check_now(8'h00, "reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) step(z, 8'h00, "idle_no_demand");

        // E (4) beats N (3); E yields after MAX_GREEN to pending N
        for (int i = 0; i < 6; i++) step(mk(0,3,4,0,0,0,0,0), 8'h30, "single_winner_E");
        step(mk(0,3,4,0,0,0,0,0), 8'h00, "single_winner_clear");
        step(mk(0,3,4,0,0,0,0,0), 8'hC0, "single_winner_N");
        step(z, 8'hC0, "drain_N_min_green");
        step(z, 8'h00, "drain_N_clear");
        step(z, 8'h00, "drain_N_idle");

        step(mk(5,0,0,5,0,0,0,0), 8'hC0, "tie_N_over_E");
        step(z, 8'hC0, "tie_drain_hold");
        step(z, 8'h00, "tie_drain_clear");
        step(z, 8'h00, "tie_drain_idle");

        step(mk(0,0,0,0,0,0,27,1), 8'h03, "idle_to_W");
        step(z, 8'h03, "W_drain_hold");
        step(z, 8'h00, "W_drain_clear");
        step(z, 8'h00, "W_drain_idle");

        // E empties after first green cycle but is held to MIN_GREEN
        step(mk(0,0,4,0,0,0,0,0), 8'h30, "early_E_grant");
        step(mk(0,0,0,0,2,0,0,0), 8'h30, "early_E_min_hold");
        step(mk(0,0,0,0,2,0,0,0), 8'h00, "early_E_clear");
        step(mk(0,0,0,0,2,0,0,0), 8'h0C, "early_S_grant");
        step(z, 8'h0C, "S_drain_hold");
        step(z, 8'h00, "S_drain_clear");
        step(z, 8'h00, "S_drain_idle");

        step(mk(255,254,0,0,0,0,255,255), 8'h03, "no_overflow_W510");
        for (int i = 0; i < 10; i++) step(mk(0,0,0,0,0,0,255,255), 8'h03, "W_past_max_green");
        // Competitor vanishes during clearance: previous approach re-granted
        step(mk(1,0,0,0,0,0,255,255), 8'h00, "W_yield_clear");
        step(mk(0,0,0,0,0,0,255,255), 8'h03, "W_regrant");
        step(z, 8'h03, "W2_drain_hold");
        step(z, 8'h00, "W2_drain_clear");
        step(z, 8'h00, "W2_drain_idle");

        step(mk(0,0,0,0,0,1,0,0), 8'h0C, "idle_new_S2");
        step(z, 8'h0C, "S2_drain_hold");
        step(z, 8'h00, "S2_drain_clear");
        step(z, 8'h00, "S2_drain_idle");

        // Asynchronous reset mid-GREEN(E) with the clock stopped
        step(mk(0,0,4,0,0,0,0,0), 8'h30, "pre_reset_E");
        step(mk(0,0,4,0,0,0,0,0), 8'h30, "pre_reset_E_hold");
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        check_now(8'h30, "stopped_clk_green_E");
        rst_n = 1'b0;
        #1;
        check_now(8'h00, "async_reset_mid_green");
        bus.car_counts = z;
        #10;
        rst_n = 1'b1;
        #3;
        clk_en = 1'b1;
        for (int i = 0; i < 10; i++) step(z, 8'h00, "post_reset_idle");

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/daytime_lane_scheduler.md
Name: daytime_lane_scheduler

Overview:
- Daytime traffic-light controller for a four-way intersection with two lanes per approach (N, E, S, W).
- Samples a per-lane waiting-car count every clock and grants green to the approach with the highest combined demand.
- Enforces minimum and maximum green times and an all-red clearance between phases.
- Sits between the lane car-counter blocks and the lamp drivers.

Parameters:
- MIN_GREEN, 2: minimum green cycles before an empty approach can be released (>=1).
- MAX_GREEN, 6: green cycles after which the approach must yield if any other approach has demand (>= MIN_GREEN).
- CLEAR_CYCLES, 1: all-red cycles between green phases (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- car_counts  in  64  eight unsigned 8-bit lane counts, lane i at [8i+7:8i]; i = 0 N1, 1 N2, 2 E1, 3 E2, 4 S1, 5 S2, 6 W1, 7 W2.
- lane_output  out  8  one bit per lane, 1 = green, 0 = red; bit7 N1, bit6 N2, bit5 E1, bit4 E2, bit3 S1, bit2 S2, bit1 W1, bit0 W2 (printed MSB-first reads NNEESSWW).

Behaviour:
- One clock domain. Reset is asynchronous and active-low; the clock port is clk and the reset port is rst_n.
- Reset: state IDLE, lane_output = 8'h00, green counter 0, current direction N. Takes effect immediately, including mid-phase.
- Demand: each approach's demand is the sum of its two lanes, computed as a 9-bit unsigned value with no overflow (max 510).
- Selection = argmax of the four demands. Ties resolve by fixed priority N > E > S > W.
- lane_output is registered and updated only on clock edges, except for reset.
- Green pattern per direction:
  - N = 11000000
  - E = 00110000
  - S = 00001100
  - W = 00000011
- States:
  - IDLE (output 0).
  - GREEN(dir) (output = dir pattern).
  - CLEAR (output 0).
- IDLE: on a clock edge where any demand > 0, go to GREEN(argmax) with the green counter = 1. The green pattern is visible immediately after that edge, so latency is one edge. Otherwise stay in IDLE.
- GREEN: the green counter g counts cycles the pattern has been shown and saturates at MAX_GREEN. On each edge:
  - If g >= MIN_GREEN and the current demand is 0, go to CLEAR.
  - Else if g >= MAX_GREEN and any other approach has demand > 0, go to CLEAR.
  - Else stay and increment g.
  - With no competing demand, green extends indefinitely.
- CLEAR: hold for CLEAR_CYCLES edges. On the final edge:
  - Choose argmax over the approaches other than the previous one.
  - If all of those are 0 but the previous approach is > 0, re-grant the previous approach.
  - If all demand is 0, go to IDLE.
  - The new GREEN starts with g = 1.
- The previous direction is excluded from selection after CLEAR to prevent starvation.
- Counts may change at any time. The only requirement is that they are stable around the rising edge; they are not latched.
- Never more than one approach is green at once. Green-to-green changes always pass through at least CLEAR_CYCLES all-red cycles.

Test Plan:
- Reset: drive rst_n=0 mid-GREEN(E) with clk stopped -> lane_output goes to 00000000 immediately. After release with all counts 0 for 10 cycles, lane_output stays 00000000.
- Single winner: N2=3, E1=4, others 0 (E demand 4 > N demand 3):
  - first edge -> 00110000;
  - after 6 green cycles, N demand 3 pending -> 1 cycle 00000000;
  - then 11000000.
- Tie and priority: N1=5, E2=5, others 0 -> 11000000. W1=27, W2=1 (W demand 28) at IDLE -> 00000011.
- Early release: E green with E1=4, then E counts drop to 0 after first green cycle, S1=2 -> E held through cycle 2 (MIN_GREEN), then 00000000 for 1 cycle, then 00001100.
- No overflow: W1=255, W2=255, N1=255, N2=254 -> W (510) wins -> 00000011. With only W demand, W stays green past MAX_GREEN.
- Drain to idle: single approach green, all counts then 0 -> after MIN_GREEN, CLEAR, then IDLE with 00000000. A new demand S2=1 -> 00001100 on the next edge.
